// File: rtl/hangman_main.sv
// Hangman game core: two debounced keypads, game FSM, status LEDs
// and four 16-char ASCII LCD line buffers (setter and guesser views).

module hangman_debounce #(
  parameter int DEBOUNCE = 100
) (
  input  logic       clk,
  input  logic       nRst,
  input  logic [3:0] row,
  output logic       evt,
  output logic [3:0] key
);
  localparam int CW = $clog2(DEBOUNCE + 1);

  logic [3:0]    s1, s2, cand, pat;
  logic [CW-1:0] cnt;
  logic          armed, stable;

  // only single-key patterns count; anything else reads as released
  always_comb begin
    pat = 4'b0000;
    if ((s2 != 4'b0000) && ((s2 & (s2 - 4'd1)) == 4'b0000))
      pat = s2;
  end

  assign stable = (pat == cand) && (cnt == CW'(DEBOUNCE - 1));
  assign evt    = stable && armed && (cand != 4'b0000);
  assign key    = cand;

  always_ff @(posedge clk or posedge nRst) begin
    if (nRst) begin
      s1    <= '0;
      s2    <= '0;
      cand  <= '0;
      cnt   <= '0;
      armed <= 1'b0;
    end else begin
      s1 <= row;
      s2 <= s1;
      if (pat != cand) begin
        cand <= pat;
        cnt  <= '0;
      end else if (!stable) begin
        cnt <= cnt + CW'(1);
      end else if (cand == 4'b0000) begin
        armed <= 1'b1;
      end else begin
        armed <= 1'b0;
      end
    end
  end
endmodule

module hangman_main #(
  parameter int DEBOUNCE = 100,
  parameter int MAX_MISS = 6
) (
  input  logic         clk,
  input  logic         nRst,
  input  logic         role_switch,
  input  logic [3:0]   input_row_host,
  input  logic [3:0]   input_row_player,
  output logic         red,
  output logic         green,
  output logic         blue,
  output logic         error,
  output logic         msg_sent,
  output logic [127:0] host_row1,
  output logic [127:0] host_row2,
  output logic [127:0] play_row1,
  output logic [127:0] play_row2
);
  typedef enum logic [1:0] {
    SET_WORD, GUESS, WIN, LOSE
  } state_t;

  localparam int MW = $clog2(MAX_MISS + 1);
  localparam logic [127:0] BLANK = {16{8'h20}};

  state_t        state;
  logic [4:0]    cur;
  logic [2:0]    cnt;
  logic [4:0]    word [5];
  logic [25:0]   guessed;
  logic [4:0]    rev, hit, rev_nx;
  logic [MW-1:0] miss, miss_nx;
  logic          role_q, eff_role;
  logic          evt_h, evt_p, act;
  logic [3:0]    key_h, key_p, akey;
  logic [4:0]    cur_up, cur_dn;
  logic [127:0]  s_r1, s_r2, g_r1, g_r2;

  hangman_debounce #(.DEBOUNCE(DEBOUNCE)) u_db_host (
    .clk(clk), .nRst(nRst), .row(input_row_host),
    .evt(evt_h), .key(key_h)
  );

  hangman_debounce #(.DEBOUNCE(DEBOUNCE)) u_db_play (
    .clk(clk), .nRst(nRst), .row(input_row_player),
    .evt(evt_p), .key(key_p)
  );

  // role tracks the switch live while the word is being set
  assign eff_role = (state == SET_WORD) ? role_switch : role_q;
  assign cur_up   = (cur == 5'd25) ? 5'd0 : cur + 5'd1;
  assign cur_dn   = (cur == 5'd0) ? 5'd25 : cur - 5'd1;
  assign miss_nx  = miss + MW'(1);
  assign rev_nx   = rev | hit;

  always_comb begin
    for (int i = 0; i < 5; i++)
      hit[i] = (word[i] == cur);
  end

  always_comb begin
    act  = 1'b0;
    akey = 4'b0000;
    unique case (state)
      SET_WORD: begin
        act  = eff_role ? evt_p : evt_h;
        akey = eff_role ? key_p : key_h;
      end
      GUESS: begin
        act  = eff_role ? evt_h : evt_p;
        akey = eff_role ? key_h : key_p;
      end
      WIN, LOSE: begin
        act  = evt_h | evt_p;
        akey = evt_h ? key_h : key_p;
      end
    endcase
  end

  always_ff @(posedge clk or posedge nRst) begin
    if (nRst) begin
      state    <= SET_WORD;
      cur      <= '0;
      cnt      <= '0;
      guessed  <= '0;
      rev      <= '0;
      miss     <= '0;
      role_q   <= 1'b0;
      red      <= 1'b0;
      green    <= 1'b0;
      blue     <= 1'b0;
      error    <= 1'b0;
      msg_sent <= 1'b0;
      for (int i = 0; i < 5; i++)
        word[i] <= '0;
    end else begin
      msg_sent <= 1'b0;
      if (state == SET_WORD)
        role_q <= role_switch;
      if (act) begin
        error <= 1'b0;
        unique case (state)
          SET_WORD: begin
            unique case (1'b1)
              akey[3]: cur <= cur_up;
              akey[2]: cur <= cur_dn;
              akey[1]: begin
                if (cnt == 3'd5) begin
                  state    <= GUESS;
                  msg_sent <= 1'b1;
                  blue     <= 1'b1;
                  cur      <= '0;
                end else begin
                  error <= 1'b1;
                end
              end
              akey[0]: begin
                cur <= '0;
                if (cnt < 3'd5) begin
                  word[cnt] <= cur;
                  cnt       <= cnt + 3'd1;
                end else begin
                  error <= 1'b1;
                end
              end
              default: ;
            endcase
          end
          GUESS: begin
            unique case (1'b1)
              akey[3]: cur <= cur_up;
              akey[2]: cur <= cur_dn;
              akey[0]: begin
                cur <= '0;
                if (guessed[cur]) begin
                  error <= 1'b1;
                end else begin
                  guessed[cur] <= 1'b1;
                  rev          <= rev_nx;
                  red          <= ~|hit;
                  green        <= |hit;
                  if (~|hit)
                    miss <= miss_nx;
                  // win wins a tie with the miss limit
                  if (&rev_nx) begin
                    state <= WIN;
                    blue  <= 1'b0;
                  end else if (~|hit &&
                               miss_nx == MW'(MAX_MISS)) begin
                    state <= LOSE;
                    blue  <= 1'b0;
                  end
                end
              end
              default: ;
            endcase
          end
          WIN, LOSE: begin
            if (akey[1]) begin
              state   <= SET_WORD;
              cur     <= '0;
              cnt     <= '0;
              guessed <= '0;
              rev     <= '0;
              miss    <= '0;
              red     <= 1'b0;
              green   <= 1'b0;
              blue    <= 1'b0;
              for (int i = 0; i < 5; i++)
                word[i] <= '0;
            end
          end
        endcase
      end
    end
  end

  always_comb begin
    s_r1 = BLANK;
    s_r2 = BLANK;
    g_r1 = BLANK;
    g_r2 = BLANK;
    for (int i = 0; i < 5; i++) begin
      if (i < int'(cnt))
        s_r1[8*(15-i) +: 8] = 8'h41 + {3'b000, word[i]};
      if (state == GUESS && !rev[i])
        g_r1[8*(15-i) +: 8] = 8'h5F;
      else if (state != SET_WORD)
        g_r1[8*(15-i) +: 8] = 8'h41 + {3'b000, word[i]};
    end
    unique case (state)
      SET_WORD: s_r2[127:120] = 8'h41 + {3'b000, cur};
      GUESS:    g_r2[127:120] = 8'h41 + {3'b000, cur};
      WIN:      g_r2[127:96]  = "WIN ";
      LOSE:     g_r2[127:96]  = "LOSE";
    endcase
    if (state != SET_WORD)
      g_r2[7:0] = 8'h30 + 8'(miss);
  end

  always_ff @(posedge clk or posedge nRst) begin
    if (nRst) begin
      host_row1 <= BLANK;
      host_row2 <= BLANK;
      play_row1 <= BLANK;
      play_row2 <= BLANK;
    end else begin
      host_row1 <= eff_role ? g_r1 : s_r1;
      host_row2 <= eff_role ? g_r2 : s_r2;
      play_row1 <= eff_role ? s_r1 : g_r1;
      play_row2 <= eff_role ? s_r2 : g_r2;
    end
  end
endmodule

// File: tb/tb_hangman_main.sv
// Bench for hangman_main: directed vector table, corner sequences,
// and random games checked against a word-level game model.

module tb_hangman_main;
  localparam int D  = 8;
  localparam int MM = 6;
  localparam logic [3:0] UP = 4'b1000;
  localparam logic [3:0] DN = 4'b0100;
  localparam logic [3:0] SW = 4'b0010;
  localparam logic [3:0] SL = 4'b0001;
  localparam logic [127:0] BLANK = {16{8'h20}};

  logic         tb_clk = 1'b0;
  logic         nRst = 1'b1;
  logic         role_switch = 1'b0;
  logic [3:0]   input_row_host = '0;
  logic [3:0]   input_row_player = '0;
  logic         red, green, blue, error, msg_sent;
  logic [127:0] host_row1, host_row2, play_row1, play_row2;

  always #5 tb_clk = ~tb_clk;

  hangman_main #(.DEBOUNCE(D), .MAX_MISS(MM)) dut (
    .clk(tb_clk), .nRst(nRst), .role_switch(role_switch),
    .input_row_host(input_row_host),
    .input_row_player(input_row_player),
    .red(red), .green(green), .blue(blue), .error(error),
    .msg_sent(msg_sent),
    .host_row1(host_row1), .host_row2(host_row2),
    .play_row1(play_row1), .play_row2(play_row2)
  );

  int checks = 0;
  int errors = 0;
  int msg_hi = 0;

  always @(negedge tb_clk)
    if (msg_sent === 1'b1) msg_hi++;

  // game model: 0 set word, 1 guess, 2 win, 3 lose
  int  m_st, m_cnt, m_cur, m_miss, m_msgs;
  byte m_word [5];
  bit  m_gs [26];
  bit  m_rev [5];
  bit  m_err, m_r, m_g, m_b, m_role;

  task automatic m_reset();
    m_st = 0; m_cnt = 0; m_cur = 0; m_miss = 0;
    m_err = 0; m_r = 0; m_g = 0; m_b = 0;
    for (int i = 0; i < 26; i++) m_gs[i] = 0;
    for (int i = 0; i < 5; i++) begin
      m_rev[i] = 0; m_word[i] = 8'h20;
    end
  endtask

  task automatic m_press(input bit pad, input logic [3:0] k);
    bit er, ok, hitb, all;
    byte l;
    er = (m_st == 0) ? role_switch : m_role;
    if (m_st == 0) ok = (pad == er);
    else if (m_st == 1) ok = (pad != er);
    else ok = 1;
    if (!ok) return;
    m_err = 0;
    if (m_st == 0) begin
      if (k == UP) m_cur = (m_cur + 1) % 26;
      if (k == DN) m_cur = (m_cur + 25) % 26;
      if (k == SL) begin
        if (m_cnt < 5) begin
          m_word[m_cnt] = 8'(65 + m_cur);
          m_cnt++;
        end else m_err = 1;
        m_cur = 0;
      end
      if (k == SW) begin
        if (m_cnt == 5) begin
          m_st = 1; m_role = role_switch;
          m_msgs++; m_b = 1; m_cur = 0;
        end else m_err = 1;
      end
    end else if (m_st == 1) begin
      if (k == UP) m_cur = (m_cur + 1) % 26;
      if (k == DN) m_cur = (m_cur + 25) % 26;
      if (k == SL) begin
        l = 8'(65 + m_cur);
        if (m_gs[m_cur]) m_err = 1;
        else begin
          m_gs[m_cur] = 1;
          hitb = 0; all = 1;
          for (int i = 0; i < 5; i++) begin
            if (m_word[i] == l) begin
              m_rev[i] = 1; hitb = 1;
            end
            all &= m_rev[i];
          end
          if (hitb) begin m_g = 1; m_r = 0; end
          else begin m_miss++; m_r = 1; m_g = 0; end
          if (all) begin
            m_st = 2; m_g = 1; m_r = 0; m_b = 0;
          end else if (m_miss == MM) begin
            m_st = 3; m_r = 1; m_g = 0; m_b = 0;
          end
        end
        m_cur = 0;
      end
    end else if (k == SW) begin
      m_reset();
    end
  endtask

  function automatic logic [127:0] exp_s1();
    logic [127:0] r = BLANK;
    for (int i = 0; i < m_cnt; i++) r[8*(15-i) +: 8] = m_word[i];
    return r;
  endfunction

  function automatic logic [127:0] exp_s2();
    logic [127:0] r = BLANK;
    if (m_st == 0) r[127:120] = 8'(65 + m_cur);
    return r;
  endfunction

  function automatic logic [127:0] exp_g1();
    logic [127:0] r = BLANK;
    if (m_st != 0)
      for (int i = 0; i < 5; i++)
        r[8*(15-i) +: 8] = (m_st == 1 && !m_rev[i]) ? 8'h5F : m_word[i];
    return r;
  endfunction

  function automatic logic [127:0] exp_g2();
    logic [127:0] r = BLANK;
    if (m_st == 1) r[127:120] = 8'(65 + m_cur);
    if (m_st == 2) r[127:96] = "WIN ";
    if (m_st == 3) r[127:96] = "LOSE";
    if (m_st != 0) r[7:0] = 8'(48 + m_miss);
    return r;
  endfunction

  task automatic chk(input string nm, input logic [127:0] act,
                     input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic check_all(input string t);
    bit er;
    er = (m_st == 0) ? role_switch : m_role;
    chk({t, "/red"}, red, m_r);
    chk({t, "/green"}, green, m_g);
    chk({t, "/blue"}, blue, m_b);
    chk({t, "/error"}, error, m_err);
    chk({t, "/msgs"}, msg_hi, m_msgs);
    chk({t, "/host1"}, host_row1, er ? exp_g1() : exp_s1());
    chk({t, "/host2"}, host_row2, er ? exp_g2() : exp_s2());
    chk({t, "/play1"}, play_row1, er ? exp_s1() : exp_g1());
    chk({t, "/play2"}, play_row2, er ? exp_s2() : exp_g2());
  endtask

  task automatic drive(input bit pad, input logic [3:0] k);
    if (pad) input_row_player = k;
    else input_row_host = k;
  endtask

  task automatic press(input bit pad, input logic [3:0] k);
    @(negedge tb_clk);
    drive(pad, k);
    repeat (D + 6) @(negedge tb_clk);
    drive(pad, 4'b0000);
    repeat (D + 6) @(negedge tb_clk);
    m_press(pad, k);
  endtask

  task automatic goto_letter(input bit pad, input int tgt);
    int d;
    d = (tgt - m_cur + 26) % 26;
    if (d <= 13) repeat (d) press(pad, UP);
    else repeat (26 - d) press(pad, DN);
  endtask

  task automatic reset_pulse(input string t);
    @(negedge tb_clk);
    nRst = 1'b1;
    repeat (3) @(negedge tb_clk);
    chk({t, "/rst_h1"}, host_row1, BLANK);
    chk({t, "/rst_h2"}, host_row2, BLANK);
    chk({t, "/rst_p1"}, play_row1, BLANK);
    chk({t, "/rst_p2"}, play_row2, BLANK);
    chk({t, "/rst_led"}, {red, green, blue, error, msg_sent}, 5'b0);
    nRst = 1'b0;
    m_reset();
  endtask

  typedef struct {
    bit         pad;
    logic [3:0] key;
    int         reps;
    bit         e_err;
    logic [2:0] e_rgb;
  } vec_t;

  vec_t tbl [$];
  logic [127:0] e;

  initial begin
    m_msgs = 0;
    m_role = 0;
    m_reset();

    // power-on reset, then first edge shows the cursor
    reset_pulse("por");
    @(negedge tb_clk);
    e = BLANK;
    e[127:120] = 8'h41;
    chk("por/first_edge_h2", host_row2, e);
    repeat (2 * D) @(negedge tb_clk);
    check_all("por");

    // long hold yields one event, short glitch none
    drive(0, UP);
    repeat (10 * D) @(negedge tb_clk);
    drive(0, 4'b0000);
    repeat (D + 6) @(negedge tb_clk);
    m_press(0, UP);
    check_all("hold");
    drive(0, UP);
    repeat (D / 2) @(negedge tb_clk);
    drive(0, 4'b0000);
    repeat (D + 6) @(negedge tb_clk);
    check_all("glitch");

    // both buses at once: only the setter keypad counts
    @(negedge tb_clk);
    input_row_host = UP;
    input_row_player = DN;
    repeat (D + 6) @(negedge tb_clk);
    input_row_host = '0;
    input_row_player = '0;
    repeat (D + 6) @(negedge tb_clk);
    m_press(0, UP);
    m_press(1, DN);
    check_all("simul");

    // key held through reset release must not fire
    drive(0, UP);
    reset_pulse("heldrst");
    repeat (3 * D) @(negedge tb_clk);
    drive(0, 4'b0000);
    repeat (2 * D + 6) @(negedge tb_clk);
    check_all("heldrst");

    // APPLE game, player wins
    tbl.push_back('{0, SL, 1, 0, 3'b000});
    tbl.push_back('{0, UP, 15, 0, 3'b000});
    tbl.push_back('{0, SL, 1, 0, 3'b000});
    tbl.push_back('{0, UP, 15, 0, 3'b000});
    tbl.push_back('{0, SL, 1, 0, 3'b000});
    tbl.push_back('{0, SW, 1, 1, 3'b000});
    tbl.push_back('{0, UP, 11, 0, 3'b000});
    tbl.push_back('{0, SL, 1, 0, 3'b000});
    tbl.push_back('{0, UP, 4, 0, 3'b000});
    tbl.push_back('{0, SL, 1, 0, 3'b000});
    tbl.push_back('{1, UP, 1, 0, 3'b000});
    tbl.push_back('{0, SW, 1, 0, 3'b001});
    tbl.push_back('{1, UP, 15, 0, 3'b001});
    tbl.push_back('{1, SL, 1, 0, 3'b011});
    tbl.push_back('{1, UP, 25, 0, 3'b011});
    tbl.push_back('{1, SL, 1, 0, 3'b101});
    tbl.push_back('{1, UP, 15, 0, 3'b101});
    tbl.push_back('{1, SL, 1, 1, 3'b101});
    tbl.push_back('{1, SL, 1, 0, 3'b011});
    tbl.push_back('{1, UP, 11, 0, 3'b011});
    tbl.push_back('{1, SL, 1, 0, 3'b011});
    tbl.push_back('{1, UP, 4, 0, 3'b011});
    tbl.push_back('{1, SL, 1, 0, 3'b010});
    role_switch = 1'b0;
    for (int v = 0; v < tbl.size(); v++) begin
      repeat (tbl[v].reps) press(tbl[v].pad, tbl[v].key);
      chk($sformatf("tbl%0d/err", v), error, tbl[v].e_err);
      chk($sformatf("tbl%0d/rgb", v), {red, green, blue},
          tbl[v].e_rgb);
      check_all($sformatf("tbl%0d", v));
    end
    e = BLANK;
    e[127:88] = "APPLE";
    chk("win/host1", host_row1, e);
    e = BLANK;
    e[127:96] = "WIN ";
    e[7:0] = "1";
    chk("win/play2", play_row2, e);

    // word AAAAA, six misses ends in LOSE
    press(0, SW);
    repeat (5) press(0, SL);
    press(0, SW);
    for (int k = 1; k <= 6; k++) begin
      repeat (k) press(1, UP);
      press(1, SL);
    end
    chk("lose/rgb", {red, green, blue}, 3'b100);
    chk("lose/miss", play_row2[7:0], 8'h36);
    e = BLANK;
    e[127:88] = "AAAAA";
    chk("lose/play1", play_row1, e);
    check_all("lose");
    press(1, SW);
    check_all("lose_exit");

    // random games with random roles
    for (int g = 0; g < 3; g++) begin
      bit sp, gp;
      int l, guard;
      role_switch = 1'($urandom_range(0, 1));
      repeat (4) @(negedge tb_clk);
      sp = role_switch;
      for (int i = 0; i < 5; i++) begin
        goto_letter(sp, $urandom_range(0, 25));
        press(sp, SL);
      end
      press(sp, SW);
      check_all($sformatf("rg%0d/start", g));
      gp = ~m_role;
      guard = 0;
      while (m_st == 1 && guard < 40) begin
        l = $urandom_range(0, 25);
        if (m_gs[l] && $urandom_range(0, 3) != 0)
          for (int j = 0; j < 26; j++)
            if (!m_gs[(l + j) % 26]) begin
              l = (l + j) % 26;
              break;
            end
        if ($urandom_range(0, 3) == 0) press(~gp, UP);
        goto_letter(gp, l);
        press(gp, SL);
        check_all($sformatf("rg%0d/g%0d", g, guard));
        guard++;
      end
      chk($sformatf("rg%0d/ended", g), 128'(m_st >= 2), 128'(1));
      press(1'($urandom_range(0, 1)), SW);
      check_all($sformatf("rg%0d/exit", g));
    end

    // reset in the middle of a game
    role_switch = 1'b0;
    repeat (4) @(negedge tb_clk);
    repeat (5) press(0, SL);
    press(0, SW);
    press(1, UP);
    press(1, SL);
    check_all("mid");
    reset_pulse("midrst");
    repeat (2 * D) @(negedge tb_clk);
    check_all("midrst");

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end
endmodule
